jellyvl_etherneco_synctimer_slave_ctl: RTL and testbench

- Wishbone-master sequencer that brings up and supervises one synctimer slave register block.
- On `start` it:
  - reads and checks the core ID,
  - writes the four correction-limit parameters, clears override, sets recv-valid,
  - then polls recv-valid periodically.
- Sits between the system CPU/boot logic and the synctimer slave, so the slave works without software.

---
 rtl/jellyvl_etherneco_synctimer_slave_ctl.sv | 256 +++++++++++++++++++++++++
 tb/tb_jellyvl_etherneco_synctimer_slave_ctl.sv | 454 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jellyvl_etherneco_synctimer_slave_ctl.sv
// Wishbone-master sequencer that brings up one synctimer slave register block:
// checks the core ID, writes the correction limits, clears override, sets
// recv-valid, then polls recv-valid periodically.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   start, stop              sequence control pulses (stop wins when both are set)
//   param_*                  correction limits, latched when start is accepted
//   m_wb_*                   Wishbone master (ack may be combinational from stb)
//   busy, done, error        sequence status; error_code 0 none, 1 ID, 2 ack timeout
//   recv_valid, poll_count   last polled recv-valid bit and completed poll count
module jellyvl_etherneco_synctimer_slave_ctl #(
  parameter int unsigned WB_ADR_WIDTH  = 16,
  parameter int unsigned WB_DAT_WIDTH  = 32,
  parameter int unsigned WB_SEL_WIDTH  = WB_DAT_WIDTH / 8,
  parameter logic [31:0] CORE_ID       = 32'hffff1122,
  parameter int unsigned POLL_INTERVAL = 1000,
  parameter int unsigned POLL_WIDTH    = 16,
  parameter int unsigned ACK_TIMEOUT   = 255
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    stop,
  input  logic [WB_DAT_WIDTH-1:0] param_limit_min,
  input  logic [WB_DAT_WIDTH-1:0] param_limit_max,
  input  logic [WB_DAT_WIDTH-1:0] param_adjust_min,
  input  logic [WB_DAT_WIDTH-1:0] param_adjust_max,
  output logic [WB_ADR_WIDTH-1:0] m_wb_adr_o,
  output logic [WB_DAT_WIDTH-1:0] m_wb_dat_o,
  input  logic [WB_DAT_WIDTH-1:0] m_wb_dat_i,
  output logic [WB_SEL_WIDTH-1:0] m_wb_sel_o,
  output logic                    m_wb_we_o,
  output logic                    m_wb_stb_o,
  input  logic                    m_wb_ack_i,
  output logic                    busy,
  output logic                    done,
  output logic                    error,
  output logic [1:0]              error_code,
  output logic                    recv_valid,
  output logic [15:0]             poll_count
);

  localparam int unsigned TO_WIDTH = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [TO_WIDTH-1:0]   TO_LAST   = TO_WIDTH'(ACK_TIMEOUT - 1);
  localparam logic [POLL_WIDTH-1:0] POLL_LOAD = POLL_WIDTH'(POLL_INTERVAL - 1);
  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_ID      = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;

  typedef enum logic [3:0] {
    ST_IDLE, ST_RD_ID, ST_WR_LMIN, ST_WR_LMAX, ST_WR_AMIN, ST_WR_AMAX,
    ST_WR_OVR, ST_WR_RV, ST_POLL_WAIT, ST_RD_RV, ST_ERROR
  } state_t;

  state_t                  state_q, state_d;
  logic                    stb_q, stb_d, we_q, we_d;
  logic [WB_ADR_WIDTH-1:0] adr_q, adr_d;
  logic [WB_DAT_WIDTH-1:0] dat_q, dat_d;
  logic                    busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic [1:0]              code_q, code_d;
  logic                    rv_q, rv_d, stop_q, stop_d;
  logic [15:0]             pcnt_q, pcnt_d;
  logic [POLL_WIDTH-1:0]   poll_q, poll_d;
  logic [TO_WIDTH-1:0]     tcnt_q, tcnt_d;
  logic [WB_DAT_WIDTH-1:0] lmin_q, lmin_d, lmax_q, lmax_d, amin_q, amin_d, amax_q, amax_d;

  logic                    bus_op, stop_req, restart;
  logic [WB_ADR_WIDTH-1:0] bus_adr;
  logic [WB_DAT_WIDTH-1:0] bus_dat;
  logic                    bus_we;
  state_t                  bus_next;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next state and registered-output next values
  always_comb begin
    state_d  = state_q;
    stb_d    = stb_q;
    we_d     = we_q;
    adr_d    = adr_q;
    dat_d    = dat_q;
    done_d   = done_q;
    err_d    = err_q;
    code_d   = code_q;
    rv_d     = rv_q;
    pcnt_d   = pcnt_q;
    poll_d   = poll_q;
    tcnt_d   = tcnt_q;
    lmin_d   = lmin_q;
    lmax_d   = lmax_q;
    amin_d   = amin_q;
    amax_d   = amax_q;
    stop_req = stop_q | stop;
    stop_d   = stop_req;
    restart  = 1'b0;
    bus_op   = 1'b1;
    bus_adr  = '0;
    bus_dat  = '0;
    bus_we   = 1'b0;
    bus_next = ST_IDLE;

    // Bus operation owned by each transaction state
    case (state_q)
      ST_RD_ID:   begin bus_adr = WB_ADR_WIDTH'('h00); bus_next = ST_WR_LMIN; end
      ST_WR_LMIN: begin bus_adr = WB_ADR_WIDTH'('h40); bus_we = 1'b1; bus_dat = lmin_q; bus_next = ST_WR_LMAX; end
      ST_WR_LMAX: begin bus_adr = WB_ADR_WIDTH'('h41); bus_we = 1'b1; bus_dat = lmax_q; bus_next = ST_WR_AMIN; end
      ST_WR_AMIN: begin bus_adr = WB_ADR_WIDTH'('h42); bus_we = 1'b1; bus_dat = amin_q; bus_next = ST_WR_AMAX; end
      ST_WR_AMAX: begin bus_adr = WB_ADR_WIDTH'('h43); bus_we = 1'b1; bus_dat = amax_q; bus_next = ST_WR_OVR; end
      ST_WR_OVR:  begin bus_adr = WB_ADR_WIDTH'('h30); bus_we = 1'b1; bus_next = ST_WR_RV; end
      ST_WR_RV:   begin bus_adr = WB_ADR_WIDTH'('h20); bus_we = 1'b1; bus_dat = WB_DAT_WIDTH'(1); bus_next = ST_POLL_WAIT; end
      ST_RD_RV:   begin bus_adr = WB_ADR_WIDTH'('h20); bus_next = ST_POLL_WAIT; end
      default:    bus_op = 1'b0;
    endcase

    if (bus_op) begin
      if (!stb_q) begin
        // Entry cycle: nothing on the bus yet, so stop/restart can act now
        if (stop_req) begin
          state_d = ST_IDLE;
          done_d  = 1'b0;
          stop_d  = 1'b0;
        end else if (state_q == ST_RD_RV && start) begin
          restart = 1'b1;
        end else begin
          stb_d  = 1'b1;
          adr_d  = bus_adr;
          dat_d  = bus_dat;
          we_d   = bus_we;
          tcnt_d = '0;
        end
      end else if (m_wb_ack_i) begin
        // Ack wins over a timeout expiring in the same cycle
        stb_d   = 1'b0;
        state_d = bus_next;
        case (state_q)
          ST_RD_ID: begin
            if (m_wb_dat_i != WB_DAT_WIDTH'(CORE_ID)) begin
              state_d = ST_ERROR;
              err_d   = 1'b1;
              code_d  = ERR_ID;
            end
          end
          ST_WR_RV: begin
            done_d = 1'b1;
            poll_d = POLL_LOAD;
          end
          ST_RD_RV: begin
            rv_d   = m_wb_dat_i[0];
            pcnt_d = 16'(pcnt_q + 16'd1);
            poll_d = POLL_LOAD;
          end
          default: ;
        endcase
        if (stop_req) begin
          state_d = ST_IDLE;
          done_d  = 1'b0;
          stop_d  = 1'b0;
        end
      end else if (tcnt_q == TO_LAST) begin
        // A pending stop is honoured from ERROR on the following cycle
        stb_d   = 1'b0;
        state_d = ST_ERROR;
        err_d   = 1'b1;
        code_d  = ERR_TIMEOUT;
        done_d  = 1'b0;
      end else begin
        tcnt_d = TO_WIDTH'(tcnt_q + 1'b1);
      end
    end else begin
      // IDLE, POLL_WAIT and ERROR: stop acts immediately and beats start
      if (stop_req) begin
        state_d = ST_IDLE;
        done_d  = 1'b0;
        stop_d  = 1'b0;
      end else if (start) begin
        restart = 1'b1;
      end else if (state_q == ST_POLL_WAIT) begin
        if (poll_q == '0) state_d = ST_RD_RV;
        else              poll_d  = POLL_WIDTH'(poll_q - 1'b1);
      end
    end

    if (restart) begin
      state_d = ST_RD_ID;
      done_d  = 1'b0;
      err_d   = 1'b0;
      code_d  = ERR_NONE;
      pcnt_d  = '0;
      lmin_d  = param_limit_min;
      lmax_d  = param_limit_max;
      amin_d  = param_adjust_min;
      amax_d  = param_adjust_max;
    end

    busy_d = state_d inside {ST_RD_ID, ST_WR_LMIN, ST_WR_LMAX, ST_WR_AMIN,
                             ST_WR_AMAX, ST_WR_OVR, ST_WR_RV};
  end

  // Output and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      stb_q  <= 1'b0;
      we_q   <= 1'b0;
      adr_q  <= '0;
      dat_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
      code_q <= ERR_NONE;
      rv_q   <= 1'b0;
      pcnt_q <= '0;
      poll_q <= '0;
      tcnt_q <= '0;
      stop_q <= 1'b0;
      lmin_q <= '0;
      lmax_q <= '0;
      amin_q <= '0;
      amax_q <= '0;
    end else begin
      stb_q  <= stb_d;
      we_q   <= we_d;
      adr_q  <= adr_d;
      dat_q  <= dat_d;
      busy_q <= busy_d;
      done_q <= done_d;
      err_q  <= err_d;
      code_q <= code_d;
      rv_q   <= rv_d;
      pcnt_q <= pcnt_d;
      poll_q <= poll_d;
      tcnt_q <= tcnt_d;
      stop_q <= stop_d;
      lmin_q <= lmin_d;
      lmax_q <= lmax_d;
      amin_q <= amin_d;
      amax_q <= amax_d;
    end
  end

  assign m_wb_adr_o = adr_q;
  assign m_wb_dat_o = dat_q;
  assign m_wb_sel_o = '1;
  assign m_wb_we_o  = we_q;
  assign m_wb_stb_o = stb_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign error      = err_q;
  assign error_code = code_q;
  assign recv_valid = rv_q;
  assign poll_count = pcnt_q;

endmodule

// File: tb/tb_jellyvl_etherneco_synctimer_slave_ctl.sv
// Self-checking bench: behavioural Wishbone slave with configurable ack delay,
// per-address no-ack and toggling recv-valid, plus a transaction log compared
// against the expected bring-up sequence.
`timescale 1ns/1ps
module tb_jellyvl_etherneco_synctimer_slave_ctl;

  localparam int unsigned AW      = 16;
  localparam int unsigned DW      = 32;
  localparam int unsigned SW      = DW / 8;
  localparam int unsigned POLL_IV = 10;
  localparam int unsigned ACK_TO  = 255;
  localparam logic [31:0] CID     = 32'hffff1122;

  typedef struct {
    logic [AW-1:0] adr;
    logic          we;
    logic [DW-1:0] dat;
  } tx_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic stop = 1'b0;
  logic [DW-1:0] p_lmin = '0, p_lmax = '0, p_amin = '0, p_amax = '0;
  logic [AW-1:0] m_wb_adr_o;
  logic [DW-1:0] m_wb_dat_o, m_wb_dat_i;
  logic [SW-1:0] m_wb_sel_o;
  logic          m_wb_we_o, m_wb_stb_o, m_wb_ack_i;
  logic          busy, done, error, recv_valid;
  logic [1:0]    error_code;
  logic [15:0]   poll_count;

  int checks = 0;
  int failures = 0;

  // Slave configuration (driven by the test sequence)
  logic [DW-1:0] id_val = CID;
  int unsigned   ack_delay = 0;
  logic          noack_en = 1'b0;
  logic [AW-1:0] noack_adr = '0;

  // Slave/monitor state (driven by the monitor only)
  int unsigned   wcnt = 0, run = 0, last_run = 0, cyc = 0, stab_err = 0, b2b_err = 0;
  logic          rv_val = 1'b1;
  logic          p_stb = 1'b0, p_ack = 1'b0, p_we = 1'b0;
  logic [AW-1:0] p_adr = '0;
  logic [DW-1:0] p_dat = '0;
  tx_t           txq[$];

  always #5 clk = ~clk;

  jellyvl_etherneco_synctimer_slave_ctl #(
    .WB_ADR_WIDTH(AW), .WB_DAT_WIDTH(DW), .WB_SEL_WIDTH(SW), .CORE_ID(CID),
    .POLL_INTERVAL(POLL_IV), .POLL_WIDTH(16), .ACK_TIMEOUT(ACK_TO)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop),
    .param_limit_min(p_lmin), .param_limit_max(p_lmax),
    .param_adjust_min(p_amin), .param_adjust_max(p_amax),
    .m_wb_adr_o(m_wb_adr_o), .m_wb_dat_o(m_wb_dat_o), .m_wb_dat_i(m_wb_dat_i),
    .m_wb_sel_o(m_wb_sel_o), .m_wb_we_o(m_wb_we_o), .m_wb_stb_o(m_wb_stb_o),
    .m_wb_ack_i(m_wb_ack_i), .busy(busy), .done(done), .error(error),
    .error_code(error_code), .recv_valid(recv_valid), .poll_count(poll_count)
  );

  assign m_wb_ack_i = m_wb_stb_o && !(noack_en && m_wb_adr_o == noack_adr) && (wcnt >= ack_delay);

  always_comb begin
    case (m_wb_adr_o)
      16'h0000: m_wb_dat_i = id_val;
      16'h0020: m_wb_dat_i = {31'd0, rv_val};
      default:  m_wb_dat_i = 32'hdeadbeef;
    endcase
  end

  // Slave timing, transaction log and bus-protocol monitor
  always @(posedge clk) begin
    tx_t t;
    cyc <= cyc + 1;
    if (rst) begin
      wcnt   <= 0;
      run    <= 0;
      rv_val <= 1'b1;
    end else begin
      wcnt <= (m_wb_stb_o && !m_wb_ack_i) ? wcnt + 1 : 0;
      if (m_wb_stb_o && m_wb_ack_i) begin
        t.adr = m_wb_adr_o;
        t.we  = m_wb_we_o;
        t.dat = m_wb_we_o ? m_wb_dat_o : m_wb_dat_i;
        txq.push_back(t);
        if (m_wb_adr_o == 16'h0020 && !m_wb_we_o) rv_val <= ~rv_val;
      end
      if (m_wb_stb_o) run <= run + 1;
      else begin
        if (run != 0) last_run <= run;
        run <= 0;
      end
      if (p_stb && !p_ack && m_wb_stb_o &&
          (m_wb_adr_o != p_adr || m_wb_dat_o != p_dat || m_wb_we_o != p_we))
        stab_err <= stab_err + 1;
      if (p_stb && p_ack && m_wb_stb_o) b2b_err <= b2b_err + 1;
    end
    p_stb <= rst ? 1'b0 : m_wb_stb_o;
    p_ack <= m_wb_ack_i;
    p_adr <= m_wb_adr_o;
    p_dat <= m_wb_dat_o;
    p_we  <= m_wb_we_o;
  end

  // Expected i-th transaction of the bring-up sequence
  function automatic tx_t exp_tx(input int i, input logic [DW-1:0] a0, a1, a2, a3);
    tx_t t;
    case (i)
      0:       begin t.adr = 16'h0000; t.we = 1'b0; t.dat = CID;   end
      1:       begin t.adr = 16'h0040; t.we = 1'b1; t.dat = a0;    end
      2:       begin t.adr = 16'h0041; t.we = 1'b1; t.dat = a1;    end
      3:       begin t.adr = 16'h0042; t.we = 1'b1; t.dat = a2;    end
      4:       begin t.adr = 16'h0043; t.we = 1'b1; t.dat = a3;    end
      5:       begin t.adr = 16'h0030; t.we = 1'b1; t.dat = 32'd0; end
      default: begin t.adr = 16'h0020; t.we = 1'b1; t.dat = 32'd1; end
    endcase
    return t;
  endfunction

  task automatic pulse_start(input logic [DW-1:0] a0, a1, a2, a3);
    @(negedge clk);
    start = 1'b1; p_lmin = a0; p_lmax = a1; p_amin = a2; p_amax = a3;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic go_idle();
    int n = 0;
    @(negedge clk); stop = 1'b1;
    @(negedge clk); stop = 1'b0;
    while ((busy || m_wb_stb_o || done) && n < 1000) begin @(negedge clk); n++; end
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || m_wb_stb_o !== 1'b0) begin
      failures++;
      $display("FAIL go_idle: busy=%b done=%b stb=%b required 0 0 0", busy, done, m_wb_stb_o);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({m_wb_stb_o, m_wb_we_o, busy, done, error, recv_valid} !== 6'b0) begin
      failures++;
      $display("FAIL reset_flags: got %b required 000000",
               {m_wb_stb_o, m_wb_we_o, busy, done, error, recv_valid});
    end
    checks++;
    if (error_code !== 2'd0) begin failures++; $display("FAIL reset_code: got %0d required 0", error_code); end
    checks++;
    if (poll_count !== 16'd0) begin failures++; $display("FAIL reset_pcnt: got %0d required 0", poll_count); end
    checks++;
    if (m_wb_adr_o !== 16'd0) begin failures++; $display("FAIL reset_adr: got %h required 0", m_wb_adr_o); end
    checks++;
    if (m_wb_dat_o !== 32'd0) begin failures++; $display("FAIL reset_dat: got %h required 0", m_wb_dat_o); end
    checks++;
    if (m_wb_sel_o !== 4'hf) begin failures++; $display("FAIL reset_sel: got %h required f", m_wb_sel_o); end
    rst = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if (m_wb_stb_o !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL idle_no_start: stb=%b busy=%b required 0 0", m_wb_stb_o, busy);
    end
  endtask

  // Full bring-up; a second start mid-sequence with new params must be ignored
  task automatic test_config(input logic [DW-1:0] a0, a1, a2, a3, input int d, input string name);
    int n;
    int base;
    tx_t e;
    go_idle();
    ack_delay = d;
    base = txq.size();
    pulse_start(a0, a1, a2, a3);
    n = 1;
    p_lmin = $urandom(); p_lmax = $urandom(); p_amin = $urandom(); p_amax = $urandom();
    while (done !== 1'b1 && error !== 1'b1 && n < 400) begin
      start = (n == 5);
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    checks++;
    if (done !== 1'b1 || error !== 1'b0) begin
      failures++;
      $display("FAIL %s done: done=%b error=%b required 1 0", name, done, error);
    end
    checks++;
    if (n != 7 * (d + 2) + 1) begin
      failures++;
      $display("FAIL %s latency: got %0d cycles required %0d", name, n, 7 * (d + 2) + 1);
    end
    checks++;
    if (txq.size() - base != 7) begin
      failures++;
      $display("FAIL %s tx_count: got %0d required 7", name, txq.size() - base);
    end else begin
      for (int i = 0; i < 7; i++) begin
        e = exp_tx(i, a0, a1, a2, a3);
        checks++;
        if (txq[base+i].adr !== e.adr || txq[base+i].we !== e.we || txq[base+i].dat !== e.dat) begin
          failures++;
          $display("FAIL %s tx%0d: got adr=%h we=%b dat=%h required adr=%h we=%b dat=%h", name, i,
                   txq[base+i].adr, txq[base+i].we, txq[base+i].dat, e.adr, e.we, e.dat);
        end
      end
    end
    checks++;
    if (poll_count !== 16'd0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL %s status: pcnt=%0d busy=%b required 0 0", name, poll_count, busy);
    end
    checks++;
    if (stab_err != 0 || b2b_err != 0) begin
      failures++;
      $display("FAIL %s bus_protocol: unstable=%0d back_to_back=%0d required 0 0", name, stab_err, b2b_err);
    end
  endtask

  task automatic test_id_mismatch();
    int n = 1;
    int base;
    go_idle();
    ack_delay = 0;
    id_val = 32'h12345678;
    base = txq.size();
    pulse_start($urandom(), $urandom(), $urandom(), $urandom());
    while (error !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    repeat (5) @(negedge clk);
    checks++;
    if (error !== 1'b1 || error_code !== 2'd1 || done !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL id_mismatch: error=%b code=%0d done=%b busy=%b required 1 1 0 0", error, error_code, done, busy);
    end
    checks++;
    if (n != 3) begin failures++; $display("FAIL id_latency: got %0d required 3", n); end
    checks++;
    if (txq.size() - base != 1 || txq[txq.size()-1].adr !== 16'h0 || txq[txq.size()-1].we !== 1'b0) begin
      failures++;
      $display("FAIL id_bus: got %0d transactions required 1 read of 0x00", txq.size() - base);
    end
    id_val = CID;
  endtask

  task automatic test_timeout();
    int n = 1;
    int base;
    go_idle();
    ack_delay = 0;
    noack_en = 1'b1;
    noack_adr = 16'h0041;
    base = txq.size();
    pulse_start($urandom(), $urandom(), $urandom(), $urandom());
    while (error !== 1'b1 && n < 1000) begin @(negedge clk); n++; end
    checks++;
    if (m_wb_stb_o !== 1'b0 || error_code !== 2'd2 || done !== 1'b0) begin
      failures++;
      $display("FAIL timeout: stb=%b code=%0d done=%b required 0 2 0", m_wb_stb_o, error_code, done);
    end
    checks++;
    if (n != 2 * 2 + int'(ACK_TO) + 2) begin
      failures++;
      $display("FAIL timeout_latency: got %0d required %0d", n, 2 * 2 + int'(ACK_TO) + 2);
    end
    @(negedge clk);
    checks++;
    if (last_run != ACK_TO) begin
      failures++;
      $display("FAIL timeout_stb_len: got %0d required %0d", last_run, ACK_TO);
    end
    checks++;
    if (txq.size() - base != 2) begin
      failures++;
      $display("FAIL timeout_tx: got %0d required 2", txq.size() - base);
    end
    noack_en = 1'b0;
    go_idle();
    checks++;
    if (error !== 1'b1 || error_code !== 2'd2) begin
      failures++;
      $display("FAIL error_retained: error=%b code=%0d required 1 2", error, error_code);
    end
  endtask

  task automatic test_polling();
    int n = 1;
    int unsigned prev_c;
    logic prev_rv = 1'b0;
    tx_t last;
    go_idle();
    ack_delay = 0;
    pulse_start($urandom(), $urandom(), $urandom(), $urandom());
    while (done !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    prev_c = cyc;
    for (int k = 1; k <= 4; k++) begin
      n = 0;
      while (poll_count !== 16'(k) && n < 200) begin @(negedge clk); n++; end
      checks++;
      if (poll_count !== 16'(k)) begin
        failures++;
        $display("FAIL poll_count%0d: got %0d required %0d", k, poll_count, k);
      end
      checks++;
      if (cyc - prev_c != POLL_IV + 2) begin
        failures++;
        $display("FAIL poll_period%0d: got %0d required %0d", k, cyc - prev_c, POLL_IV + 2);
      end
      last = txq[txq.size()-1];
      checks++;
      if (last.adr !== 16'h0020 || last.we !== 1'b0 || recv_valid !== last.dat[0]) begin
        failures++;
        $display("FAIL poll_read%0d: adr=%h we=%b rv=%b required 0020 0 %b", k, last.adr, last.we, recv_valid, last.dat[0]);
      end
      if (k > 1) begin
        checks++;
        if (recv_valid === prev_rv) begin
          failures++;
          $display("FAIL poll_toggle%0d: got %b required %b", k, recv_valid, ~prev_rv);
        end
      end
      checks++;
      if (done !== 1'b1 || busy !== 1'b0) begin
        failures++;
        $display("FAIL poll_status%0d: done=%b busy=%b required 1 0", k, done, busy);
      end
      prev_c = cyc;
      prev_rv = recv_valid;
    end
    pulse_start($urandom(), $urandom(), $urandom(), $urandom());
    checks++;
    if (poll_count !== 16'd0 || done !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL restart_from_poll: pcnt=%0d done=%b busy=%b required 0 0 1", poll_count, done, busy);
    end
  endtask

  task automatic test_stop();
    int n = 0;
    int base;
    int n43 = 0;
    logic saw_stb = 1'b0;
    logic [DW-1:0] a2;
    go_idle();
    ack_delay = 2;
    a2 = $urandom();
    base = txq.size();
    pulse_start($urandom(), $urandom(), a2, $urandom());
    while (!(m_wb_stb_o && m_wb_adr_o == 16'h0042) && n < 200) begin @(negedge clk); n++; end
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    n = 0;
    while (busy && n < 50) begin @(negedge clk); n++; end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (m_wb_stb_o) saw_stb = 1'b1;
    end
    for (int i = base; i < txq.size(); i++) if (txq[i].adr == 16'h0043) n43++;
    checks++;
    if (txq[txq.size()-1].adr !== 16'h0042 || txq[txq.size()-1].dat !== a2) begin
      failures++;
      $display("FAIL stop_last_write: adr=%h dat=%h required 0042 %h", txq[txq.size()-1].adr, txq[txq.size()-1].dat, a2);
    end
    checks++;
    if (n43 != 0 || saw_stb !== 1'b0) begin
      failures++;
      $display("FAIL stop_no_more_bus: writes_0x43=%0d later_stb=%b required 0 0", n43, saw_stb);
    end
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || error !== 1'b0) begin
      failures++;
      $display("FAIL stop_state: busy=%b done=%b error=%b required 0 0 0", busy, done, error);
    end
    // Stop while waiting between polls acts immediately
    ack_delay = 0;
    pulse_start($urandom(), $urandom(), $urandom(), $urandom());
    n = 0;
    while (done !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    repeat (2) @(negedge clk);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL stop_in_poll: done=%b busy=%b required 0 0", done, busy);
    end
    // Start and stop together from IDLE: stop wins
    saw_stb = 1'b0;
    @(negedge clk);
    start = 1'b1; stop = 1'b1;
    @(negedge clk);
    start = 1'b0; stop = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (m_wb_stb_o || busy) saw_stb = 1'b1;
      @(negedge clk);
    end
    checks++;
    if (saw_stb !== 1'b0) begin
      failures++;
      $display("FAIL start_stop_same: activity=%b required 0", saw_stb);
    end
  endtask

  task automatic test_reset_mid();
    int n = 0;
    go_idle();
    ack_delay = 0;
    noack_en = 1'b1;
    noack_adr = 16'h0040;
    pulse_start($urandom(), $urandom(), $urandom(), $urandom());
    while (!(m_wb_stb_o && m_wb_adr_o == 16'h0040) && n < 100) begin @(negedge clk); n++; end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (m_wb_stb_o !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || error !== 1'b0 ||
        error_code !== 2'd0 || poll_count !== 16'd0 || m_wb_adr_o !== 16'd0) begin
      failures++;
      $display("FAIL reset_mid: stb=%b busy=%b done=%b error=%b code=%0d pcnt=%0d adr=%h required all 0",
               m_wb_stb_o, busy, done, error, error_code, poll_count, m_wb_adr_o);
    end
    rst = 1'b0;
    noack_en = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if (m_wb_stb_o !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_idle: stb=%b busy=%b required 0 0", m_wb_stb_o, busy);
    end
  endtask

  initial begin
    test_reset();
    test_config(32'hfffe7960, 32'h000186a0, 32'hfffffc18, 32'h000003e8, 0, "nominal");
    test_config($urandom(), $urandom(), $urandom(), $urandom(), 3, "ack_delay3");
    for (int r = 0; r < 4; r++)
      test_config($urandom(), $urandom(), $urandom(), $urandom(), int'($urandom_range(0, 3)), "random_cfg");
    test_id_mismatch();
    test_timeout();
    test_config($urandom(), $urandom(), $urandom(), $urandom(), 1, "after_error");
    test_polling();
    test_stop();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
